// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for the OpenMIPS32 core.
// Carries the decoded instruction into EX and handles stall, bubble and flush.
module id_ex_reg #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stall,
    input  logic                   flush,
    input  logic [7:0]             id_aluop,
    input  logic [2:0]             id_alusel,
    input  logic [31:0]            id_reg1,
    input  logic [31:0]            id_reg2,
    input  logic [4:0]             id_wd_addr,
    input  logic                   id_wreg,
    input  logic [31:0]            id_link_addr,
    input  logic                   id_is_in_delayslot,
    input  logic                   next_inst_in_delayslot_i,
    output logic [7:0]             ex_aluop,
    output logic [2:0]             ex_alusel,
    output logic [31:0]            ex_reg1,
    output logic [31:0]            ex_reg2,
    output logic [4:0]             ex_wd_addr,
    output logic                   ex_wreg,
    output logic [31:0]            ex_link_addr,
    output logic                   ex_is_in_delayslot,
    output logic                   is_in_delayslot_o,
    output logic                   ex_valid,
    output logic [STALL_CNT_W-1:0] bubble_cnt
);

    logic id_stop;
    logic ex_stop;
    logic do_bubble;
    logic unused_stall;

    assign id_stop      = stall[2];
    assign ex_stop      = stall[3];
    assign do_bubble    = id_stop && !ex_stop;
    assign unused_stall = ^{stall[5:4], stall[1:0]};

    always_ff @(posedge clk) begin
        if (rst || flush || do_bubble) begin
            ex_aluop           <= 8'h00;
            ex_alusel          <= 3'b000;
            ex_reg1            <= 32'h0;
            ex_reg2            <= 32'h0;
            ex_wd_addr         <= 5'd0;
            ex_wreg            <= 1'b0;
            ex_link_addr       <= 32'h0;
            ex_is_in_delayslot <= 1'b0;
            ex_valid           <= 1'b0;
        end else if (!id_stop) begin
            ex_aluop           <= id_aluop;
            ex_alusel          <= id_alusel;
            ex_reg1            <= id_reg1;
            ex_reg2            <= id_reg2;
            ex_wd_addr         <= id_wd_addr;
            ex_wreg            <= id_wreg;
            ex_link_addr       <= id_link_addr;
            ex_is_in_delayslot <= id_is_in_delayslot;
            ex_valid           <= 1'b1;
        end
    end

    // A bubble keeps the branch context so the delay slot survives the stall
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            is_in_delayslot_o <= 1'b0;
        end else if (!id_stop) begin
            is_in_delayslot_o <= next_inst_in_delayslot_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!flush && do_bubble && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + STALL_CNT_W'(1);
        end
    end

    // ctrl never stops EX while letting ID run
    a_legal_stall: assert property (
        @(posedge clk) disable iff (rst) !(ex_stop && !id_stop)
    );

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: vector table, random run against a
// reference model, and counter saturation on a narrow instance.
module tb_id_ex_reg;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] link;
        logic        ds;
    } dp_t;

    typedef struct {
        bit        rst;
        bit        flush;
        logic [5:0] stall;
        dp_t       in;
        bit        nids;
        dp_t       exp_dp;
        bit        exp_v;
        bit        exp_dso;
        int        exp_cnt;
    } vec_t;

    localparam dp_t ZERO  = '0;
    localparam dp_t OR_IN = '{8'h25, 3'b001, 32'h0000_F0F0, 32'h0F0F_0000,
                              5'd3, 1'b1, 32'h0, 1'b0};
    localparam dp_t B_IN  = '{8'h20, 3'b100, 32'hDEAD_BEEF, 32'h1234_5678,
                              5'd31, 1'b1, 32'hBFC0_0010, 1'b1};
    localparam logic [5:0] S_RUN  = 6'b000000;
    localparam logic [5:0] S_BUB  = 6'b000111;
    localparam logic [5:0] S_HOLD = 6'b001111;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [5:0]  stall;
    dp_t         din;
    logic        nids;

    logic [7:0]  a16, a4;
    logic [2:0]  s16, s4;
    logic [31:0] r1_16, r1_4, r2_16, r2_4, l16, l4;
    logic [4:0]  w16, w4;
    logic        we16, we4, ds16, ds4;
    logic        dso16, dso4, v16, v4;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;

    dp_t out16, out4;
    assign out16 = {a16, s16, r1_16, r2_16, w16, we16, l16, ds16};
    assign out4  = {a4, s4, r1_4, r2_4, w4, we4, l4, ds4};

    always #5 clk = ~clk;

    id_ex_reg #(.STALL_CNT_W(16)) dut16 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_aluop(din.aluop), .id_alusel(din.alusel),
        .id_reg1(din.reg1), .id_reg2(din.reg2),
        .id_wd_addr(din.wd), .id_wreg(din.wreg),
        .id_link_addr(din.link), .id_is_in_delayslot(din.ds),
        .next_inst_in_delayslot_i(nids),
        .ex_aluop(a16), .ex_alusel(s16), .ex_reg1(r1_16), .ex_reg2(r2_16),
        .ex_wd_addr(w16), .ex_wreg(we16), .ex_link_addr(l16),
        .ex_is_in_delayslot(ds16), .is_in_delayslot_o(dso16),
        .ex_valid(v16), .bubble_cnt(cnt16)
    );

    id_ex_reg #(.STALL_CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_aluop(din.aluop), .id_alusel(din.alusel),
        .id_reg1(din.reg1), .id_reg2(din.reg2),
        .id_wd_addr(din.wd), .id_wreg(din.wreg),
        .id_link_addr(din.link), .id_is_in_delayslot(din.ds),
        .next_inst_in_delayslot_i(nids),
        .ex_aluop(a4), .ex_alusel(s4), .ex_reg1(r1_4), .ex_reg2(r2_4),
        .ex_wd_addr(w4), .ex_wreg(we4), .ex_link_addr(l4),
        .ex_is_in_delayslot(ds4), .is_in_delayslot_o(dso4),
        .ex_valid(v4), .bubble_cnt(cnt4)
    );

    int errs = 0;
    int checks = 0;

    // reference model: what EX should see, and how many bubbles since reset
    dp_t m_dp = '0;
    bit  m_v = 1'b0;
    bit  m_dso = 1'b0;
    int  m_n = 0;

    function automatic int sat(int n, int w);
        int mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic check_all(string nm, dp_t edp, bit ev, bit edso, int en);
        chk({nm, " dp16"}, 128'(out16), 128'(edp));
        chk({nm, " dp4"}, 128'(out4), 128'(edp));
        chk({nm, " valid"}, 128'({v16, v4}), 128'({ev, ev}));
        chk({nm, " dso"}, 128'({dso16, dso4}), 128'({edso, edso}));
        chk({nm, " cnt16"}, 128'(cnt16), 128'(sat(en, 16)));
        chk({nm, " cnt4"}, 128'(cnt4), 128'(sat(en, 4)));
    endtask

    task automatic step(bit r, bit f, logic [5:0] s, dp_t in, bit n);
        rst   = r;
        flush = f;
        stall = s;
        din   = in;
        nids  = n;
        @(posedge clk);
        #1;
        if (r) begin
            m_dp = '0; m_v = 0; m_dso = 0; m_n = 0;
        end else if (f) begin
            m_dp = '0; m_v = 0; m_dso = 0;
        end else if (s[2] && !s[3]) begin
            m_dp = '0; m_v = 0; m_n = m_n + 1;
        end else if (!s[2]) begin
            m_dp = in; m_v = 1; m_dso = n;
        end
    endtask

    function automatic dp_t rand_dp();
        dp_t d;
        d.aluop  = 8'($urandom);
        d.alusel = 3'($urandom);
        d.reg1   = $urandom;
        d.reg2   = $urandom;
        d.wd     = 5'($urandom);
        d.wreg   = 1'($urandom);
        d.link   = $urandom;
        d.ds     = 1'($urandom);
        return d;
    endfunction

    function automatic vec_t mk(bit r, bit f, logic [5:0] s, dp_t in, bit n,
                                dp_t e, bit ev, bit edso, int ec);
        vec_t t;
        t.rst = r; t.flush = f; t.stall = s; t.in = in; t.nids = n;
        t.exp_dp = e; t.exp_v = ev; t.exp_dso = edso; t.exp_cnt = ec;
        return t;
    endfunction

    vec_t tbl[16];
    logic [5:0] legal[6];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(1, 0, S_RUN,  OR_IN, 1, ZERO,  0, 0, 0);
        tbl[1]  = mk(1, 0, S_RUN,  OR_IN, 1, ZERO,  0, 0, 0);
        tbl[2]  = mk(0, 0, S_RUN,  OR_IN, 0, OR_IN, 1, 0, 0);
        tbl[3]  = mk(0, 0, S_BUB,  B_IN,  1, ZERO,  0, 0, 1);
        tbl[4]  = mk(0, 0, S_BUB,  B_IN,  1, ZERO,  0, 0, 2);
        tbl[5]  = mk(0, 0, S_BUB,  B_IN,  1, ZERO,  0, 0, 3);
        tbl[6]  = mk(0, 0, S_RUN,  OR_IN, 0, OR_IN, 1, 0, 3);
        tbl[7]  = mk(0, 0, S_HOLD, B_IN,  1, OR_IN, 1, 0, 3);
        tbl[8]  = mk(0, 0, S_HOLD, B_IN,  1, OR_IN, 1, 0, 3);
        tbl[9]  = mk(0, 0, S_HOLD, B_IN,  1, OR_IN, 1, 0, 3);
        tbl[10] = mk(0, 0, S_HOLD, B_IN,  1, OR_IN, 1, 0, 3);
        tbl[11] = mk(0, 0, S_RUN,  B_IN,  1, B_IN,  1, 1, 3);
        tbl[12] = mk(0, 0, S_BUB,  OR_IN, 0, ZERO,  0, 1, 4);
        tbl[13] = mk(0, 1, S_HOLD, OR_IN, 1, ZERO,  0, 0, 4);
        tbl[14] = mk(0, 0, S_RUN,  B_IN,  0, B_IN,  1, 0, 4);
        tbl[15] = mk(0, 1, S_BUB,  B_IN,  1, ZERO,  0, 0, 4);

        legal[0] = 6'b000000; legal[1] = 6'b000011; legal[2] = 6'b000111;
        legal[3] = 6'b001111; legal[4] = 6'b011111; legal[5] = 6'b111111;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rst, tbl[i].flush, tbl[i].stall, tbl[i].in,
                 tbl[i].nids);
            check_all($sformatf("vec%0d", i), tbl[i].exp_dp, tbl[i].exp_v,
                      tbl[i].exp_dso, tbl[i].exp_cnt);
        end

        for (int i = 0; i < 400; i++) begin
            bit r = ($urandom_range(99) < 3);
            bit f = ($urandom_range(99) < 8);
            step(r, f, legal[$urandom_range(5)], rand_dp(), 1'($urandom));
            check_all($sformatf("rnd%0d", i), m_dp, m_v, m_dso, m_n);
        end

        step(1, 0, S_RUN, B_IN, 1);
        check_all("sat_rst", m_dp, m_v, m_dso, m_n);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, S_BUB, rand_dp(), 1'($urandom));
            check_all($sformatf("sat%0d", i), m_dp, m_v, m_dso, m_n);
        end
        chk("sat_cnt4_top", 128'(cnt4), 128'(4'hF));
        chk("sat_cnt16_20", 128'(cnt16), 128'(16'd20));
        step(1, 0, S_BUB, rand_dp(), 1);
        chk("sat_mid_rst4", 128'(cnt4), 128'(0));
        chk("sat_mid_rst16", 128'(cnt16), 128'(0));
        step(0, 0, S_BUB, rand_dp(), 0);
        chk("sat_restart4", 128'(cnt4), 128'(1));
        check_all("sat_restart", m_dp, m_v, m_dso, m_n);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
